reg_file_scb: RTL and testbench
===============================

Name: reg_file_scb

Overview:
Parametrised successor to the 16x16 register file for the pipelined RISC core. It provides:
- N-entry, W-bit storage with two combinational read ports and one write port.
- Optional hardwired-zero register 0 and write-to-read bypass.
- A per-register busy scoreboard. The issue stage marks destinations pending, the writeback stage clears them, and the block raises a stall on RAW/WAW hazards.

It sits between decode/issue and writeback and replaces the plain register file.

Parameters:
DATA_W, 16, register width in bits
ADDR_W, 4, address width; NREGS = 2**ADDR_W (derived localparam, not overridable)
ZERO_REG, 1, 1 = register 0 reads as 0, ignores writes, is never busy
BYPASS, 1, 1 = same-cycle writeback data/busy-clear visible on read ports and hazard logic
CNT_W, ADDR_W+1, width of pending_cnt

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
rs_addr  in  ADDR_W  read port A address (source of issuing instruction)
rt_addr  in  ADDR_W  read port B address
rs_data  out  DATA_W  read port A data (combinational)
rt_data  out  DATA_W  read port B data (combinational)
iss_valid  in  1  issuing instruction present
iss_wr  in  1  issuing instruction writes a register
iss_rd  in  ADDR_W  destination of issuing instruction
stall  out  1  hazard; issue not accepted this cycle (combinational)
wb_en  in  1  writeback strobe
wb_addr  in  ADDR_W  writeback destination
wb_data  in  DATA_W  writeback data
pending_cnt  out  CNT_W  number of registers currently busy
wb_err  out  1  sticky: writeback to a non-busy register occurred

Behaviour:
- Reset (rst=0, async):
  - All registers cleared to 0, all busy bits cleared.
  - pending_cnt=0, wb_err=0.
  - rs_data/rt_data read 0.
  - stall=0 (no busy bits).
  - Reset mid-operation discards all pending state immediately.
- Write: on rising clk with wb_en=1, mem[wb_addr] <= wb_data.
  - Ignored when ZERO_REG=1 and wb_addr=0.
  - Single-cycle write latency.
- Read:
  - rs_data = mem[rs_addr], combinational.
  - If BYPASS=1 and wb_en=1 and wb_addr==rs_addr (and not the zero register), rs_data = wb_data.
  - ZERO_REG=1 and rs_addr=0 gives 0.
  - rt_data follows the same rules on port B.
- Effective busy: eb[a] = busy[a] & ~(BYPASS & wb_en & wb_addr==a). eb[0] is 0 when ZERO_REG=1.
- Stall: stall = iss_valid & (eb[rs_addr] | eb[rt_addr] | (iss_wr & eb[iss_rd])).
  - Covers RAW on both sources and WAW on the destination.
  - Both sources are always checked; the issue stage presents addresses of unused operands as 0.
- Accepted issue = iss_valid & ~stall.
  - If also iss_wr, and iss_rd is not a zero-register target, busy[iss_rd] <= 1 on the next edge.
- Writeback clear:
  - wb_en & busy[wb_addr] clears busy[wb_addr].
  - wb_en to a non-busy, non-zero register still writes data and sets wb_err=1, which holds until reset.
- Same-cycle writeback and accepted issue to the same address: the issue wins. busy stays 1 and the data is written; no wb_err if busy was set.
- pending_cnt:
  - +1 on an accepted issue that sets a previously clear bit.
  - −1 on a writeback that clears a set bit.
  - Both in the same cycle: net change.
  - Always equals popcount(busy). Max NREGS−ZERO_REG; it never wraps.
- No storage reads are registered; hazard and read data are valid in the same cycle as the addresses.

Decomposition:
- Package reg_file_pkg: default DATA_W/ADDR_W constants and a function clog2 used for CNT_W checks.
- One sub-module, reg_scoreboard: busy vector, stall logic, pending_cnt, wb_err.
- Storage array and bypass muxes remain in the top module.

Test Plan:
- Reset, then write R3=16'hA5A5 via wb, then read rs_addr=3 next cycle → rs_data=16'hA5A5; rt_addr=0 → 16'h0000.
- wb_en with wb_addr=0, data 16'hFFFF (ZERO_REG=1) → R0 reads 0; pending_cnt unchanged; wb_err=0.
- Issue rd=5 accepted → next cycle pending_cnt=1. Issue reading rs=5 → stall=1. Same cycle as wb to 5 with 16'h1234 (BYPASS=1) → stall=0, rs_data=16'h1234, pending_cnt=0 after the edge.
- Issue rd=7 pending; a second issue with rd=7 → stall=1 (WAW). After wb to 7, re-issue accepted and busy[7]=1 again.
- Issue rd=2 pending, then same-cycle wb to 2 and new issue rd=2 → busy[2] stays 1, pending_cnt stays 1, wb_err=0.
- wb to R9 while not busy → wb_err=1 and persists. Fill all 15 non-zero registers busy → pending_cnt=15. Assert rst mid-stream → pending_cnt=0, stall=0 immediately.

Source files
------------

// File: rtl/reg_file_pkg.sv
// Shared defaults and elaboration helpers for the scoreboarded register file.
package reg_file_pkg;

  localparam int unsigned DefDataW = 16;
  localparam int unsigned DefAddrW = 4;

  // Ceiling log2, usable in constant expressions for parameter sanity checks.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    res = 0;
    while ((64'd1 << res) < 64'(value)) begin
      res++;
    end
    return res;
  endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register busy tracking: RAW/WAW stall, pending count and sticky
// writeback-to-idle-register error.
module reg_scoreboard
  import reg_file_pkg::*;
#(
  parameter int unsigned ADDR_W   = DefAddrW,
  parameter bit          ZERO_REG = 1'b1,
  parameter bit          BYPASS   = 1'b1,
  parameter int unsigned CNT_W    = ADDR_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  input  logic              iss_valid,
  input  logic              iss_wr,
  input  logic [ADDR_W-1:0] iss_rd,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_addr,
  output logic              stall,
  output logic [CNT_W-1:0]  pending_cnt,
  output logic              wb_err
);

  localparam int unsigned NREGS = 2 ** ADDR_W;

  if (CNT_W < clog2(NREGS + 1)) begin : g_cnt_w_check
    $error("CNT_W is too narrow to count every register");
  end

  logic [NREGS-1:0] busy_q, busy_d, eff_busy;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             iss_zero, wb_zero;
  logic             accept, set_busy, clr_busy, inc, dec;

  // A writeback landing this cycle already satisfies its consumers.
  always_comb begin
    eff_busy = busy_q;
    if (BYPASS && wb_en) begin
      eff_busy[wb_addr] = 1'b0;
    end
    if (ZERO_REG) begin
      eff_busy[0] = 1'b0;
    end
  end

  assign stall = iss_valid &
                 (eff_busy[rs_addr] | eff_busy[rt_addr] | (iss_wr & eff_busy[iss_rd]));

  assign accept   = iss_valid & ~stall;
  assign iss_zero = ZERO_REG && (iss_rd == '0);
  assign wb_zero  = ZERO_REG && (wb_addr == '0);
  assign set_busy = accept & iss_wr & ~iss_zero;
  assign clr_busy = wb_en & busy_q[wb_addr];

  // Issue is applied after the clear so a same-address issue keeps the bit set.
  always_comb begin
    busy_d = busy_q;
    if (clr_busy) begin
      busy_d[wb_addr] = 1'b0;
    end
    if (set_busy) begin
      busy_d[iss_rd] = 1'b1;
    end
  end

  assign inc   = set_busy & ~busy_q[iss_rd];
  assign dec   = clr_busy & ~(set_busy & (iss_rd == wb_addr));
  assign cnt_d = cnt_q + CNT_W'(inc) - CNT_W'(dec);
  assign err_d = err_q | (wb_en & ~busy_q[wb_addr] & ~wb_zero);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
    end
  end

  assign pending_cnt = cnt_q;
  assign wb_err      = err_q;

endmodule

// File: rtl/reg_file_scb.sv
// Parametrised register file with two combinational read ports, one write
// port, optional zero register and writeback bypass, plus a busy scoreboard.
module reg_file_scb
  import reg_file_pkg::*;
#(
  parameter int unsigned DATA_W   = DefDataW,
  parameter int unsigned ADDR_W   = DefAddrW,
  parameter bit          ZERO_REG = 1'b1,
  parameter bit          BYPASS   = 1'b1,
  parameter int unsigned CNT_W    = ADDR_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  input  logic              iss_valid,
  input  logic              iss_wr,
  input  logic [ADDR_W-1:0] iss_rd,
  output logic              stall,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic [CNT_W-1:0]  pending_cnt,
  output logic              wb_err
);

  localparam int unsigned NREGS = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [NREGS];
  logic              wr_en;

  assign wr_en = wb_en && !(ZERO_REG && (wb_addr == '0));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en) begin
      mem_q[wb_addr] <= wb_data;
    end
  end

  // Zero register check comes first so a bypass can never leak into R0.
  always_comb begin
    rs_data = mem_q[rs_addr];
    if (ZERO_REG && (rs_addr == '0)) begin
      rs_data = '0;
    end else if (BYPASS && wb_en && (wb_addr == rs_addr)) begin
      rs_data = wb_data;
    end
  end

  always_comb begin
    rt_data = mem_q[rt_addr];
    if (ZERO_REG && (rt_addr == '0)) begin
      rt_data = '0;
    end else if (BYPASS && wb_en && (wb_addr == rt_addr)) begin
      rt_data = wb_data;
    end
  end

  reg_scoreboard #(
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG),
    .BYPASS   (BYPASS),
    .CNT_W    (CNT_W)
  ) u_scoreboard (
    .clk         (clk),
    .rst         (rst),
    .rs_addr     (rs_addr),
    .rt_addr     (rt_addr),
    .iss_valid   (iss_valid),
    .iss_wr      (iss_wr),
    .iss_rd      (iss_rd),
    .wb_en       (wb_en),
    .wb_addr     (wb_addr),
    .stall       (stall),
    .pending_cnt (pending_cnt),
    .wb_err      (wb_err)
  );

endmodule

// File: tb/tb_reg_file_scb.sv
// Directed self-checking bench for reg_file_scb with default parameters.
module tb_reg_file_scb;

  logic        clk;
  logic        rst;
  logic [3:0]  rs_addr, rt_addr, iss_rd, wb_addr;
  logic [15:0] rs_data, rt_data, wb_data;
  logic        iss_valid, iss_wr, stall, wb_en, wb_err;
  logic [4:0]  pending_cnt;

  int errors = 0;
  int checks = 0;

  reg_file_scb dut (
    .clk         (clk),
    .rst         (rst),
    .rs_addr     (rs_addr),
    .rt_addr     (rt_addr),
    .rs_data     (rs_data),
    .rt_data     (rt_data),
    .iss_valid   (iss_valid),
    .iss_wr      (iss_wr),
    .iss_rd      (iss_rd),
    .stall       (stall),
    .wb_en       (wb_en),
    .wb_addr     (wb_addr),
    .wb_data     (wb_data),
    .pending_cnt (pending_cnt),
    .wb_err      (wb_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rs_addr = 4'd0; rt_addr = 4'd0;
    iss_valid = 1'b0; iss_wr = 1'b0; iss_rd = 4'd0;
    wb_en = 1'b0; wb_addr = 4'd0; wb_data = 16'h0000;
  endtask

  task automatic issue(input logic [3:0] rd);
    idle();
    iss_valid = 1'b1; iss_wr = 1'b1; iss_rd = rd;
  endtask

  task automatic writeback(input logic [3:0] a, input logic [15:0] d);
    idle();
    wb_en = 1'b1; wb_addr = a; wb_data = d;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b0;
    #12;
    iss_valid = 1'b1; rs_addr = 4'd3; rt_addr = 4'd5;
    #1;
    checks++;
    if (rs_data !== 16'h0000) begin
      errors++; $display("FAIL reset_rs_data: got %h want 0000", rs_data);
    end
    checks++;
    if (rt_data !== 16'h0000) begin
      errors++; $display("FAIL reset_rt_data: got %h want 0000", rt_data);
    end
    checks++;
    if (stall !== 1'b0) begin
      errors++; $display("FAIL reset_stall: got %b want 0", stall);
    end
    checks++;
    if (pending_cnt !== 5'd0 || wb_err !== 1'b0) begin
      errors++; $display("FAIL reset_cnt_err: got cnt=%0d err=%b want 0/0", pending_cnt, wb_err);
    end
    idle();
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_write_read();
    issue(4'd3);
    tick();
    writeback(4'd3, 16'hA5A5);
    tick();
    idle();
    rs_addr = 4'd3; rt_addr = 4'd0;
    #1;
    checks++;
    if (rs_data !== 16'hA5A5) begin
      errors++; $display("FAIL write_read_rs: got %h want a5a5", rs_data);
    end
    checks++;
    if (rt_data !== 16'h0000) begin
      errors++; $display("FAIL write_read_r0: got %h want 0000", rt_data);
    end
    checks++;
    if (pending_cnt !== 5'd0 || wb_err !== 1'b0) begin
      errors++; $display("FAIL write_read_cnt: got cnt=%0d err=%b want 0/0", pending_cnt, wb_err);
    end
  endtask

  task automatic test_zero_reg();
    writeback(4'd0, 16'hFFFF);
    tick();
    idle();
    rs_addr = 4'd0; rt_addr = 4'd0;
    #1;
    checks++;
    if (rs_data !== 16'h0000 || rt_data !== 16'h0000) begin
      errors++; $display("FAIL zero_reg_read: got %h/%h want 0000/0000", rs_data, rt_data);
    end
    checks++;
    if (pending_cnt !== 5'd0 || wb_err !== 1'b0) begin
      errors++; $display("FAIL zero_reg_cnt: got cnt=%0d err=%b want 0/0", pending_cnt, wb_err);
    end
  endtask

  task automatic test_raw_bypass();
    issue(4'd5);
    #1;
    checks++;
    if (stall !== 1'b0) begin
      errors++; $display("FAIL raw_first_issue: got stall=%b want 0", stall);
    end
    tick();
    idle();
    #1;
    checks++;
    if (pending_cnt !== 5'd1) begin
      errors++; $display("FAIL raw_cnt_set: got %0d want 1", pending_cnt);
    end
    iss_valid = 1'b1; rs_addr = 4'd5;
    #1;
    checks++;
    if (stall !== 1'b1) begin
      errors++; $display("FAIL raw_stall_rs: got %b want 1", stall);
    end
    rs_addr = 4'd0; rt_addr = 4'd5;
    #1;
    checks++;
    if (stall !== 1'b1) begin
      errors++; $display("FAIL raw_stall_rt: got %b want 1", stall);
    end
    rs_addr = 4'd5; rt_addr = 4'd0;
    wb_en = 1'b1; wb_addr = 4'd5; wb_data = 16'h1234;
    #1;
    checks++;
    if (stall !== 1'b0 || rs_data !== 16'h1234) begin
      errors++; $display("FAIL raw_bypass: got stall=%b data=%h want 0/1234", stall, rs_data);
    end
    tick();
    idle();
    #1;
    checks++;
    if (pending_cnt !== 5'd0) begin
      errors++; $display("FAIL raw_cnt_clear: got %0d want 0", pending_cnt);
    end
  endtask

  task automatic test_waw();
    issue(4'd7);
    tick();
    #1;
    checks++;
    if (stall !== 1'b1) begin
      errors++; $display("FAIL waw_stall: got %b want 1", stall);
    end
    tick();
    idle();
    #1;
    checks++;
    if (pending_cnt !== 5'd1) begin
      errors++; $display("FAIL waw_rejected_cnt: got %0d want 1", pending_cnt);
    end
    writeback(4'd7, 16'h0707);
    tick();
    idle();
    rs_addr = 4'd7;
    #1;
    checks++;
    if (pending_cnt !== 5'd0 || rs_data !== 16'h0707) begin
      errors++; $display("FAIL waw_wb: got cnt=%0d data=%h want 0/0707", pending_cnt, rs_data);
    end
    issue(4'd7);
    #1;
    checks++;
    if (stall !== 1'b0) begin
      errors++; $display("FAIL waw_reissue: got stall=%b want 0", stall);
    end
    tick();
    idle();
    iss_valid = 1'b1; rt_addr = 4'd7;
    #1;
    checks++;
    if (pending_cnt !== 5'd1 || stall !== 1'b1) begin
      errors++; $display("FAIL waw_busy_again: got cnt=%0d stall=%b want 1/1", pending_cnt, stall);
    end
    writeback(4'd7, 16'h7777);
    tick();
    idle();
  endtask

  task automatic test_issue_wins();
    issue(4'd2);
    tick();
    issue(4'd2);
    wb_en = 1'b1; wb_addr = 4'd2; wb_data = 16'hBEEF;
    #1;
    checks++;
    if (stall !== 1'b0) begin
      errors++; $display("FAIL wins_stall: got %b want 0", stall);
    end
    tick();
    idle();
    iss_valid = 1'b1; rs_addr = 4'd2;
    #1;
    checks++;
    if (pending_cnt !== 5'd1 || wb_err !== 1'b0) begin
      errors++; $display("FAIL wins_cnt_err: got cnt=%0d err=%b want 1/0", pending_cnt, wb_err);
    end
    checks++;
    if (stall !== 1'b1 || rs_data !== 16'hBEEF) begin
      errors++; $display("FAIL wins_busy_data: got stall=%b data=%h want 1/beef", stall, rs_data);
    end
    writeback(4'd2, 16'h2222);
    tick();
    idle();
  endtask

  task automatic test_wb_err();
    writeback(4'd9, 16'h9999);
    #1;
    checks++;
    if (wb_err !== 1'b0) begin
      errors++; $display("FAIL wb_err_early: got %b want 0", wb_err);
    end
    tick();
    idle();
    #1;
    checks++;
    if (wb_err !== 1'b1 || pending_cnt !== 5'd0) begin
      errors++; $display("FAIL wb_err_set: got err=%b cnt=%0d want 1/0", wb_err, pending_cnt);
    end
    tick();
    tick();
    rs_addr = 4'd9;
    #1;
    checks++;
    if (wb_err !== 1'b1 || rs_data !== 16'h9999) begin
      errors++; $display("FAIL wb_err_hold: got err=%b data=%h want 1/9999", wb_err, rs_data);
    end
  endtask

  task automatic test_fill_and_reset();
    for (int r = 1; r < 16; r++) begin
      issue(4'(r));
      tick();
    end
    idle();
    #1;
    checks++;
    if (pending_cnt !== 5'd15) begin
      errors++; $display("FAIL fill_cnt: got %0d want 15", pending_cnt);
    end
    issue(4'd0);
    #1;
    checks++;
    if (stall !== 1'b0) begin
      errors++; $display("FAIL fill_r0_issue: got stall=%b want 0", stall);
    end
    tick();
    idle();
    iss_valid = 1'b1; rs_addr = 4'd4; rt_addr = 4'd9;
    #1;
    checks++;
    if (pending_cnt !== 5'd15 || stall !== 1'b1) begin
      errors++; $display("FAIL fill_r0_cnt: got cnt=%0d stall=%b want 15/1", pending_cnt, stall);
    end
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (pending_cnt !== 5'd0 || stall !== 1'b0) begin
      errors++; $display("FAIL midreset_cnt_stall: got cnt=%0d stall=%b want 0/0", pending_cnt, stall);
    end
    checks++;
    if (wb_err !== 1'b0 || rt_data !== 16'h0000) begin
      errors++; $display("FAIL midreset_err_data: got err=%b data=%h want 0/0000", wb_err, rt_data);
    end
    tick();
    rst = 1'b1;
    tick();
    #1;
    checks++;
    if (pending_cnt !== 5'd0 || stall !== 1'b0) begin
      errors++; $display("FAIL post_reset: got cnt=%0d stall=%b want 0/0", pending_cnt, stall);
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_zero_reg();
    test_raw_bypass();
    test_waw();
    test_issue_wins();
    test_wb_err();
    test_fill_and_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
